mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: HOLD_ON_ILLEGAL, default 1, meaning 1 = stay in TRAP until reset and 0 = return to FETCH after one TRAP cycle.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  instr[6:0] from instruction register.
REQ-005 funct3  input  3  instr[14:12]; funct7b5  input  1  instr[30].
REQ-006 zero  input  1  ALU zero flag; mem_ready  input  1  memory completes current access.
REQ-007 mem_req  output  1  memory access request; mem_write  output  1  store strobe; adr_src  output  1  0 = PC, 1 = result.
REQ-008 pc_write  output  1  PC load; ir_write  output  1  instruction register and old_pc load; reg_write  output  1  register file write.
REQ-009 alu_src_a  output  2  00 = PC, 01 = old_pc, 10 = rd1; alu_src_b  output  2  00 = rd2, 01 = imm_ext, 10 = constant 4.
REQ-010 alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt; ext_imm_sel  output  2  00 I, 01 S, 10 B, 11 J.
REQ-011 res_src  output  2  00 = alu_out register, 01 = read data, 10 = ALU result; illegal  output  1  sticky decode fault.

Function
REQ-012 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, JALR, JALWB, TRAP.
REQ-013 Outputs SHALL be Moore functions of state, with the exceptions stated in REQ-015, REQ-021 and REQ-023. Every output not listed for a state SHALL be 0.
REQ-014 FETCH: mem_req=1, adr_src=0, a=00, b=10, add, res_src=10. Stay in FETCH while mem_ready=0.
REQ-015 FETCH with mem_ready=1: pc_write=1 and ir_write=1 for exactly that cycle, then go to DECODE.
REQ-016 DECODE: a=01, b=01, add (alu_out <= old_pc+imm), ext_imm_sel=10.
REQ-017 DECODE next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALR; any other op -> TRAP.
REQ-018 MEMADR: a=10, b=01, add. ext_imm_sel=00 for lw, 01 for sw. Next state is MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: mem_req=1, adr_src=1, res_src=00. Wait for mem_ready, then go to MEMWB. MEMWB: res_src=01, reg_write=1, then go to FETCH.
REQ-020 MEMWR: mem_req=1, mem_write=1, adr_src=1, res_src=00. Both held stable until mem_ready, then go to FETCH.
REQ-021 EXECR/EXECI: a=10, b=00 for EXECR and 01 for EXECI, ext_imm_sel=00. ALU op comes from alu_decoder. Next state ALUWB.
REQ-022 alu_decoder funct3 mapping: 000 -> add, except sub when EXECR and funct7b5=1; 010 -> slt; 110 -> or; 111 -> and. Any other funct3 -> TRAP instead of ALUWB.
REQ-023 ALUWB: res_src=00, reg_write=1, then go to FETCH. BEQ: a=10, b=00, sub, res_src=00, pc_write=zero, then go to FETCH.
REQ-024 JAL: a=01, b=10, add, res_src=00, pc_write=1, then go to ALUWB (rd <= old_pc+4).
REQ-025 JALR: a=10, b=01, add, ext_imm_sel=00, res_src=10, pc_write=1, then go to JALWB. JALWB: a=01, b=10, add, res_src=10, reg_write=1, then go to FETCH.
REQ-026 TRAP: illegal set, all strobes 0. Hold in TRAP if HOLD_ON_ILLEGAL=1, otherwise go to FETCH. illegal clears only on reset.
REQ-027 Handshake: mem_req SHALL never deassert before mem_ready is sampled high. mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-028 At most one of pc_write, reg_write, mem_write (qualified by mem_ready) SHALL take effect per cycle.

Reset
REQ-029 reset=0 SHALL asynchronously force state=FETCH and illegal=0.
REQ-030 While reset=0, mem_req, mem_write, pc_write, ir_write and reg_write SHALL be 0.
REQ-031 Reset mid-access SHALL abandon the access. The first mem_req SHALL occur in the first cycle after release.

Structure
REQ-032 Shared package riscv_ctrl_pkg SHALL hold the opcode constants, state enum, alu_control/ext_imm_sel/res_src/alu_src encodings and HOLD_ON_ILLEGAL default.
REQ-033 Combinational funct decode SHALL live in one sub-module, alu_decoder. The FSM register and output logic stay in mc_controller.

Verification
REQ-034 lw (op 0000011) with mem_ready delayed 2 cycles in FETCH and MEMRD: FETCH x3, DECODE, MEMADR, MEMRD x3, MEMWB. reg_write=1 with res_src=01 for exactly 1 cycle.
REQ-035 R-type op 0110011, funct3 000, funct7b5 1: EXECR alu_control=001, then ALUWB reg_write=1. Same with op 0010011 and funct7b5 1: alu_control=000.
REQ-036 beq with zero=1: pc_write=1 in BEQ. With zero=0: pc_write stays 0 and the next state is FETCH.
REQ-037 jalr: JALR pc_write=1 with res_src=10, then JALWB reg_write=1 with a=01, b=10. No overlap of strobes.
REQ-038 op 0000000: TRAP, illegal=1, mem_req=0 held for 20 cycles (HOLD_ON_ILLEGAL=1). Reset clears it and FETCH resumes.
REQ-039 reset asserted asynchronously in MEMWR with mem_write=1: mem_write drops before the next clock edge. State is FETCH after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared constants for the multi-cycle RISC-V control path.
//                Covers opcodes, FSM states, ALU/immediate/result/operand
//                select encodings and the default illegal-op behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // Opcodes recognised by the decode stage
  localparam logic [6:0] c_op_lw    = 7'b0000011;
  localparam logic [6:0] c_op_sw    = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_itype = 7'b0010011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_JALWB  = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  // ALU operation select
  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  // Immediate extension format
  localparam logic [1:0] c_imm_i = 2'b00;
  localparam logic [1:0] c_imm_s = 2'b01;
  localparam logic [1:0] c_imm_b = 2'b10;
  localparam logic [1:0] c_imm_j = 2'b11;

  // Result mux select
  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_rdata  = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  // ALU operand selects
  localparam logic [1:0] c_src_a_pc    = 2'b00;
  localparam logic [1:0] c_src_a_oldpc = 2'b01;
  localparam logic [1:0] c_src_a_rd1   = 2'b10;
  localparam logic [1:0] c_src_b_rd2   = 2'b00;
  localparam logic [1:0] c_src_b_imm   = 2'b01;
  localparam logic [1:0] c_src_b_four  = 2'b10;

  // 1 = park in TRAP until reset, 0 = single TRAP cycle then refetch
  localparam bit c_hold_on_illegal_default = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational funct3/funct7 decode into an ALU operation
//                for register and immediate arithmetic instructions. Flags
//                unsupported funct3 values so the FSM can trap.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       is_rtype,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       funct_bad
);

  // Map funct3 to an ALU op; only register-register forms may subtract
  always_comb begin
    alu_control = c_alu_add;
    funct_bad   = 1'b0;
    case (funct3)
      3'b000:  alu_control = (is_rtype && funct7b5) ? c_alu_sub : c_alu_add;
      3'b010:  alu_control = c_alu_slt;
      3'b110:  alu_control = c_alu_or;
      3'b111:  alu_control = c_alu_and;
      default: funct_bad   = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Multi-cycle RISC-V control FSM. Moore outputs per state,
//                except the FETCH load strobes (qualified by mem_ready), the
//                BEQ PC load (qualified by zero) and the EXEC ALU op (from
//                alu_decoder). Unknown opcodes or funct3 values trap and set
//                a sticky illegal flag that only reset clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit HOLD_ON_ILLEGAL = c_hold_on_illegal_default
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] ext_imm_sel,
  output logic [1:0] res_src,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       mem_req_c, mem_write_c, pc_write_c, ir_write_c, reg_write_c;
  logic [2:0] w_dec_alu;
  logic       w_dec_bad;

  alu_decoder u_alu_decoder (
    .is_rtype    (state_q == S_EXECR),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (w_dec_alu),
    .funct_bad   (w_dec_bad)
  );

  // State and sticky fault registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection and per-state control outputs
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = c_src_a_pc;
    alu_src_b   = c_src_b_rd2;
    alu_control = c_alu_add;
    ext_imm_sel = c_imm_i;
    res_src     = c_res_aluout;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = c_src_b_four;
        res_src   = c_res_alu;
        if (mem_ready) begin
          pc_write_c = 1'b1;
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a   = c_src_a_oldpc;
        alu_src_b   = c_src_b_imm;
        ext_imm_sel = c_imm_b;
        case (op)
          c_op_lw, c_op_sw: state_d = S_MEMADR;
          c_op_rtype:       state_d = S_EXECR;
          c_op_itype:       state_d = S_EXECI;
          c_op_beq:         state_d = S_BEQ;
          c_op_jal:         state_d = S_JAL;
          c_op_jalr:        state_d = S_JALR;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = c_src_a_rd1;
        alu_src_b   = c_src_b_imm;
        ext_imm_sel = (op == c_op_sw) ? c_imm_s : c_imm_i;
        state_d     = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src     = c_res_rdata;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a   = c_src_a_rd1;
        alu_src_b   = (state_q == S_EXECI) ? c_src_b_imm : c_src_b_rd2;
        alu_control = w_dec_alu;
        state_d     = w_dec_bad ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = c_src_a_rd1;
        alu_control = c_alu_sub;
        pc_write_c  = zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = c_src_a_oldpc;
        alu_src_b  = c_src_b_four;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = c_src_a_rd1;
        alu_src_b  = c_src_b_imm;
        res_src    = c_res_alu;
        pc_write_c = 1'b1;
        state_d    = S_JALWB;
      end
      S_JALWB: begin
        alu_src_a   = c_src_a_oldpc;
        alu_src_b   = c_src_b_four;
        res_src     = c_res_alu;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        if (!HOLD_ON_ILLEGAL) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  // Strobes are forced low while reset is held, independent of the clock
  assign mem_req   = mem_req_c   & reset;
  assign mem_write = mem_write_c & reset;
  assign pc_write  = pc_write_c  & reset;
  assign ir_write  = ir_write_c  & reset;
  assign reg_write = reg_write_c & reset;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Self-checking bench for mc_controller. A per-instruction
//                trace model lists the visible control outputs each cycle;
//                one compare process checks the DUT against it, and a few
//                literal checks cover reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, pc_write, ir_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, ext_imm_sel, res_src;
  logic [2:0] alu_control;

  mc_controller #(.HOLD_ON_ILLEGAL(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .ext_imm_sel (ext_imm_sel),
    .res_src     (res_src),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_write,adr_src,pc_write,ir_write,reg_write,a[1:0],b[1:0],alu[2:0],ext[1:0],res[1:0],illegal}
  logic [17:0] act;
  assign act = {mem_req, mem_write, adr_src, pc_write, ir_write, reg_write,
                alu_src_a, alu_src_b, alu_control, ext_imm_sel, res_src, illegal};

  localparam logic [17:0] ALL      = 18'h3FFFF;
  localparam logic [17:0] NO_ALU   = 18'h3FF1F;
  localparam logic [17:0] STROBES  = 18'h3F001;
  localparam logic [6:0]  OP_LW    = 7'b0000011;
  localparam logic [6:0]  OP_SW    = 7'b0100011;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_BEQ   = 7'b1100011;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;

  typedef struct {
    string       nm;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [17:0] e;
    logic [17:0] care;
  } step_t;

  step_t q[$];
  step_t exp_s;
  logic  exp_valid = 1'b0;
  int    total = 0;
  int    bad = 0;

  logic       model_ill = 1'b0;
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_f7 = 1'b0;
  logic       cur_z  = 1'b0;

  // Cycle-by-cycle comparison against the model trace
  always begin
    @(negedge clk);
    #2;
    if (exp_valid) begin
      total++;
      if ((act & exp_s.care) !== (exp_s.e & exp_s.care)) begin
        bad++;
        $display("FAIL %s: got %05h want %05h (care %05h) at %0t",
                 exp_s.nm, act, exp_s.e, exp_s.care, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %05h want %05h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [17:0] pk(input logic mreq, input logic mw, input logic adr,
                                     input logic pcw, input logic irw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [1:0] ext,
                                     input logic [1:0] res);
    return {mreq, mw, adr, pcw, irw, rw, a, b, alu, ext, res, model_ill};
  endfunction

  task automatic push(input string nm, input logic rdy, input logic [17:0] e, input logic [17:0] care);
    step_t s;
    s.nm = nm; s.rdy = rdy; s.z = cur_z; s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
    s.e = e; s.care = care;
    q.push_back(s);
  endtask

  // ALU op required by the arithmetic rules; -1 marks an unsupported funct3
  function automatic int exp_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic m_fetch(input int fw);
    for (int i = 0; i < fw; i++)
      push("fetch_wait", 1'b0, pk(1,0,0,0,0,0,2'd0,2'd2,3'd0,2'd0,2'd2), ALL);
    push("fetch", 1'b1, pk(1,0,0,1,1,0,2'd0,2'd2,3'd0,2'd0,2'd2), ALL);
  endtask

  task automatic m_trap(input int n);
    model_ill = 1'b1;
    for (int i = 0; i < n; i++)
      push("trap", 1'b1, pk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
  endtask

  // Visible trace of one instruction: fw/mw = wait cycles before mem_ready,
  // nz = drive mem_ready high in cycles where it must be ignored
  task automatic m_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw, input logic nz);
    int c;
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    m_fetch(fw);
    push("decode", nz, pk(0,0,0,0,0,0,2'd1,2'd1,3'd0,2'd2,2'd0), ALL);
    case (o)
      OP_LW: begin
        push("lw_adr", nz, pk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,2'd0), ALL);
        for (int i = 0; i < mw; i++)
          push("lw_rd_wait", 1'b0, pk(1,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
        push("lw_rd", 1'b1, pk(1,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
        push("lw_wb", nz, pk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,2'd1), ALL);
      end
      OP_SW: begin
        push("sw_adr", nz, pk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd1,2'd0), ALL);
        for (int i = 0; i < mw; i++)
          push("sw_wr_wait", 1'b0, pk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
        push("sw_wr", 1'b1, pk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
      end
      OP_R, OP_I: begin
        c = exp_alu(f3, f7, o == OP_R);
        if (c < 0) begin
          push("exec_bad", nz, pk(0,0,0,0,0,0,2'd2,(o == OP_I) ? 2'd1 : 2'd0,3'd0,2'd0,2'd0), NO_ALU);
          m_trap(5);
        end else begin
          push("exec", nz, pk(0,0,0,0,0,0,2'd2,(o == OP_I) ? 2'd1 : 2'd0,3'(c),2'd0,2'd0), ALL);
          push("alu_wb", nz, pk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
        end
      end
      OP_BEQ:  push("beq", nz, pk(0,0,0,z,0,0,2'd2,2'd0,3'd1,2'd0,2'd0), ALL);
      OP_JAL: begin
        push("jal", nz, pk(0,0,0,1,0,0,2'd1,2'd2,3'd0,2'd0,2'd0), ALL);
        push("jal_wb", nz, pk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
      end
      OP_JALR: begin
        push("jalr", nz, pk(0,0,0,1,0,0,2'd2,2'd1,3'd0,2'd0,2'd2), ALL);
        push("jalr_wb", nz, pk(0,0,0,0,0,1,2'd1,2'd2,3'd0,2'd0,2'd2), ALL);
      end
      default: m_trap(20);
    endcase
  endtask

  // Must be entered at a falling edge; returns at a falling edge
  task automatic run_queue();
    while (q.size() > 0) begin
      exp_s     = q.pop_front();
      mem_ready = exp_s.rdy;
      zero      = exp_s.z;
      op        = exp_s.op;
      funct3    = exp_s.f3;
      funct7b5  = exp_s.f7;
      exp_valid = 1'b1;
      @(negedge clk);
    end
    exp_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: all strobes and illegal low
    repeat (2) @(negedge clk);
    #2 chk("rst_strobes", act & STROBES, 18'h0);
    @(negedge clk);
    reset = 1'b1;
    #2 chk("pin_fetch_after_release", act, 18'h20204);
    @(negedge clk);

    m_instr(OP_LW,   3'b010, 1'b0, 1'b0, 2, 2, 1'b0);
    m_instr(OP_SW,   3'b010, 1'b0, 1'b0, 0, 1, 1'b1);
    m_instr(OP_R,    3'b000, 1'b1, 1'b0, 0, 0, 1'b1);
    m_instr(OP_I,    3'b000, 1'b1, 1'b0, 1, 0, 1'b0);
    m_instr(OP_R,    3'b110, 1'b0, 1'b0, 0, 0, 1'b0);
    m_instr(OP_R,    3'b111, 1'b0, 1'b0, 0, 0, 1'b1);
    m_instr(OP_I,    3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    m_instr(OP_R,    3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    m_instr(OP_BEQ,  3'b000, 1'b0, 1'b1, 0, 0, 1'b1);
    m_instr(OP_BEQ,  3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
    m_instr(OP_JAL,  3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    m_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
    m_instr(OP_LW,   3'b010, 1'b0, 1'b0, 0, 0, 1'b1);
    m_instr(OP_R,    3'b001, 1'b0, 1'b0, 0, 0, 1'b0);
    run_queue();

    // Reset out of the funct3 trap clears illegal
    reset = 1'b0;
    #2 chk("rst_clears_ill", act & STROBES, 18'h0);
    @(negedge clk);
    reset = 1'b1;
    model_ill = 1'b0;

    // Unknown opcode: parked in TRAP with only illegal high
    m_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_queue();
    #2 chk("pin_trap", act, 18'h00001);
    reset = 1'b0;
    #1 chk("trap_rst_async", act & STROBES, 18'h0);
    @(negedge clk);
    reset = 1'b1;
    model_ill = 1'b0;
    m_instr(OP_I, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
    run_queue();

    // Reset landing in the middle of a store
    cur_op = OP_SW; cur_f3 = 3'b010; cur_f7 = 1'b0; cur_z = 1'b0;
    m_fetch(0);
    push("decode", 1'b0, pk(0,0,0,0,0,0,2'd1,2'd1,3'd0,2'd2,2'd0), ALL);
    push("sw_adr", 1'b0, pk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd1,2'd0), ALL);
    push("sw_wr_wait", 1'b0, pk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0), ALL);
    run_queue();
    #2 chk("pin_memwr", act, 18'h38000);
    reset = 1'b0;
    #1 chk("memwr_rst_drop", act & STROBES, 18'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("pin_fetch_after_store_rst", act, 18'h20204);
    @(negedge clk);
    m_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
